// File: rtl/debouncer.sv
// Per-bit synchronizing debouncer with registered rise/fall edge pulses.
// Optional two-flop input synchronizer enabled by defining DEBOUNCER_SYNC_EN.
module debouncer #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned STABLE_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pb_1,
  output logic [WIDTH-1:0] pb_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] s_in;

`ifdef DEBOUNCER_SYNC_EN
  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = pb_1;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign s_in = sync2_q;
`else
  assign s_in = pb_1;
`endif

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] pb_out_q, pb_out_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  // A differing input must persist until the terminal count; any agreement clears the count.
  always_comb begin
    pb_out_d = pb_out_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_d[i] = '0;
      if (s_in[i] != pb_out_q[i]) begin
        if (cnt_q[i] == TERM_CNT) begin
          pb_out_d[i] = s_in[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    rise_d = pb_out_d & ~pb_out_q;
    fall_d = ~pb_out_d & pb_out_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= '0;
      end
      pb_out_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      pb_out_q <= pb_out_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign pb_out = pb_out_q;
  assign rise   = rise_q;
  assign fall   = fall_q;

endmodule

// File: tb/tb_debouncer.sv
// Directed self-checking bench for debouncer (WIDTH=4, STABLE_CYCLES=3).
// Expected latency follows whether DEBOUNCER_SYNC_EN is defined.
module tb_debouncer;

`ifdef DEBOUNCER_SYNC_EN
  localparam int unsigned LAT = 5;
`else
  localparam int unsigned LAT = 3;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] pb_1;
  logic [3:0] pb_out;
  logic [3:0] rise;
  logic [3:0] fall;

  int n_checks = 0;
  int n_errors = 0;

  debouncer #(.WIDTH(4), .STABLE_CYCLES(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .pb_1   (pb_1),
    .pb_out (pb_out),
    .rise   (rise),
    .fall   (fall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges; inputs are driven and outputs sampled 1ns after the edge.
  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int first_hi;
    int n_rise;
    clk  = 1'b0;
    rst  = 1'b0;
    pb_1 = 4'hF;

    // Asynchronous reset acts before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_pb_out", 32'(pb_out), 32'h0);
    check("rst_rise",   32'(rise),   32'h0);
    check("rst_fall",   32'(fall),   32'h0);
    ticks(2);
    check("rst_held", 32'(pb_out), 32'h0);
    rst = 1'b0;

    // Held-high input after release.
    ticks(LAT - 1);
    check("rel_before", 32'(pb_out), 32'h0);
    ticks(1);
    check("rel_pb_out", 32'(pb_out), 32'hF);
    check("rel_rise",   32'(rise),   32'hF);
    check("rel_fall",   32'(fall),   32'h0);
    ticks(1);
    check("rel_rise_end", 32'(rise), 32'h0);
    pb_1 = 4'h0;
    ticks(LAT - 1);
    check("relf_before", 32'(pb_out), 32'hF);
    ticks(1);
    check("relf_pb_out", 32'(pb_out), 32'h0);
    check("relf_fall",   32'(fall),   32'hF);
    ticks(1);
    check("relf_fall_end", 32'(fall), 32'h0);

    // Two-clock glitch on bit 0 is discarded.
    pb_1 = 4'h1;
    ticks(2);
    pb_1 = 4'h0;
    for (int k = 0; k < 8; k++) begin
      ticks(1);
      check("glitch", 32'({rise, pb_out}), 32'h0);
    end

    // Clean press of 4'h5 held 6 clocks.
    pb_1 = 4'h5;
    ticks(LAT - 1);
    check("press_before", 32'(pb_out), 32'h0);
    ticks(1);
    check("press_pb_out", 32'(pb_out), 32'h5);
    check("press_rise",   32'(rise),   32'h5);
    ticks(6 - LAT);
    pb_1 = 4'h0;
    ticks(LAT - 1);
    check("unpress_before", 32'(pb_out), 32'h5);
    ticks(1);
    check("unpress_pb_out", 32'(pb_out), 32'h0);
    check("unpress_fall",   32'(fall),   32'h5);
    check("unpress_rise",   32'(rise),   32'h0);
    ticks(1);
    check("unpress_fall_end", 32'(fall), 32'h0);

    // Chatter on bit 2, then settles high.
    for (int k = 0; k < 8; k++) begin
      pb_1 = (k % 2 == 0) ? 4'h4 : 4'h0;
      ticks(1);
      check("chatter_hold", 32'(pb_out), 32'h0);
    end
    pb_1 = 4'h4;
    first_hi = 0;
    n_rise   = 0;
    for (int k = 1; k <= int'(LAT) + 3; k++) begin
      ticks(1);
      if (pb_out[2] && first_hi == 0) first_hi = k;
      if (rise[2]) n_rise++;
    end
    check("chatter_latency", 32'(first_hi), 32'(LAT));
    check("chatter_rises",   32'(n_rise),   32'd1);
    check("chatter_pb_out",  32'(pb_out),   32'h4);
    pb_1 = 4'h0;
    ticks(LAT + 1);
    check("chatter_clear", 32'(pb_out), 32'h0);

    // Bit 3 pressed while bit 1 glitches for one clock.
    pb_1 = 4'hA;
    ticks(1);
    pb_1 = 4'h8;
    ticks(LAT - 2);
    check("indep_before", 32'(pb_out), 32'h0);
    ticks(1);
    check("indep_pb_out", 32'(pb_out), 32'h8);
    check("indep_rise",   32'(rise),   32'h8);
    pb_1 = 4'h0;
    ticks(LAT + 1);
    check("indep_clear", 32'(pb_out), 32'h0);

    // Plain 4'hA press.
    pb_1 = 4'hA;
    ticks(LAT - 1);
    check("a_before", 32'(pb_out), 32'h0);
    ticks(1);
    check("a_pb_out", 32'(pb_out), 32'hA);
    check("a_rise",   32'(rise),   32'hA);

    // Async reset while output is high and a rise pulse is live.
    pb_1 = 4'hF;
    ticks(LAT);
    check("ar_pre_pb_out", 32'(pb_out), 32'hF);
    check("ar_pre_rise",   32'(rise),   32'h5);
    #2 rst = 1'b1;
    #1;
    check("ar_pb_out", 32'(pb_out), 32'h0);
    check("ar_rise",   32'(rise),   32'h0);
    ticks(1);
    rst = 1'b0;

    // Reset mid-count aborts qualification; it restarts from scratch.
    ticks(LAT - 2);
    check("abort_mid", 32'(pb_out), 32'h0);
    rst = 1'b1;
    ticks(1);
    rst = 1'b0;
    ticks(LAT - 1);
    check("abort_before", 32'(pb_out), 32'h0);
    ticks(1);
    check("abort_pb_out", 32'(pb_out), 32'hF);
    check("abort_rise",   32'(rise),   32'hF);
    pb_1 = 4'h0;
    ticks(LAT + 1);
    check("abort_clear", 32'(pb_out), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
